// File: rtl/fp_scale_pkg.sv
// Shared constants, classification enum and stage-1 record for the
// complex exponent scaler.
package fp_scale_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX        = 8'hFF;
  localparam logic [EXP_W-1:0] EXP_MAX_FINITE = 8'hFE;

  typedef enum logic [1:0] {
    ZERO,
    NORMAL,
    SPECIAL
  } fp_class_e;

  typedef struct packed {
    logic             sign;
    fp_class_e        cls;
    logic [EXP_W:0]   esum;
    logic [MAN_W-1:0] man;
    logic             ovf;
  } comp_p1_t;

endpackage

// File: rtl/fp_exp_scale.sv
// Combinational classify-and-add for one IEEE-754 single component:
// splits fields, classifies the word and adds SHIFT to the biased exponent.
module fp_exp_scale
  import fp_scale_pkg::*;
#(
  parameter int SHIFT = 5
) (
  input  logic [31:0] word_i,
  output comp_p1_t    rec_o
);

  logic [EXP_W-1:0] exp_in;

  always_comb begin
    exp_in      = word_i[30:23];
    rec_o.sign  = word_i[31];
    rec_o.man   = word_i[22:0];
    rec_o.esum  = {1'b0, exp_in};
    rec_o.cls   = NORMAL;
    rec_o.ovf   = 1'b0;
    if (exp_in == '0) begin
      rec_o.cls = ZERO;
    end else if (exp_in == EXP_MAX) begin
      rec_o.cls = SPECIAL;
    end else begin
      // 9-bit sum: SHIFT <= 31 on an exponent <= 254 cannot exceed 285
      rec_o.esum = {1'b0, exp_in} + (EXP_W + 1)'(SHIFT);
      rec_o.ovf  = (rec_o.esum > {1'b0, EXP_MAX_FINITE});
    end
  end

endmodule

// File: rtl/fp_cplx_scale_up.sv
// Two-stage streaming complex scaler: multiplies re/img by 2^SHIFT.
// Overflow behaviour selected by macro FP_SCALE_SAT_EN (saturate vs. infinity).
module fp_cplx_scale_up
  import fp_scale_pkg::*;
#(
  parameter int SHIFT = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_re,
  input  logic [31:0]      s_img,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_re,
  output logic [31:0]      m_img,
  output logic             m_last,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             clr_cnt
);

  function automatic logic [31:0] sat_word(input logic sign);
`ifdef FP_SCALE_SAT_EN
    return {sign, EXP_MAX_FINITE, {MAN_W{1'b1}}};
`else
    return {sign, EXP_MAX, {MAN_W{1'b0}}};
`endif
  endfunction

  function automatic logic [31:0] assemble(input comp_p1_t r);
    logic [31:0] w;
    case (r.cls)
      ZERO:    w = {r.sign, 31'h0};
      SPECIAL: w = {r.sign, EXP_MAX, r.man};
      default: w = r.ovf ? sat_word(r.sign) : {r.sign, r.esum[EXP_W-1:0], r.man};
    endcase
    return w;
  endfunction

  logic       en;
  comp_p1_t   re_rec, img_rec;
  comp_p1_t   re_p1_q, img_p1_q;
  logic       last_p1_q;
  logic       vld_p1_q, vld_p2_q;
  logic [31:0] re_p2_q, img_p2_q, re_p2_d, img_p2_d;
  logic       last_p2_q;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic       smp_ovf;

  assign en      = !vld_p2_q || m_ready;
  assign s_ready = en;

  fp_exp_scale #(.SHIFT(SHIFT)) u_re  (.word_i(s_re),  .rec_o(re_rec));
  fp_exp_scale #(.SHIFT(SHIFT)) u_img (.word_i(s_img), .rec_o(img_rec));

  // ---- stage 1: classified records ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
    end else if (en) begin
      vld_p1_q <= s_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      re_p1_q   <= re_rec;
      img_p1_q  <= img_rec;
      last_p1_q <= s_last;
    end
  end

  // ---- stage 2: output words and overflow count ----
  always_comb begin
    re_p2_d  = assemble(re_p1_q);
    img_p2_d = assemble(img_p1_q);
    smp_ovf  = re_p1_q.ovf || img_p1_q.ovf;
    ovf_cnt_d = ovf_cnt_q;
    if (clr_cnt) begin
      ovf_cnt_d = '0;
    end else if (en && vld_p1_q && smp_ovf && (ovf_cnt_q != '1)) begin
      // counted on entry to stage 2 only, so a later stall cannot recount it
      ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2_q  <= 1'b0;
      re_p2_q   <= '0;
      img_p2_q  <= '0;
      last_p2_q <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
      if (en) begin
        vld_p2_q  <= vld_p1_q;
        re_p2_q   <= re_p2_d;
        img_p2_q  <= img_p2_d;
        last_p2_q <= last_p1_q;
      end
    end
  end

  assign m_valid = vld_p2_q;
  assign m_re    = re_p2_q;
  assign m_img   = img_p2_q;
  assign m_last  = last_p2_q;
  assign ovf_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_fp_cplx_scale_up.sv
// Scoreboard bench for fp_cplx_scale_up: directed cases plus random traffic
// with random backpressure, checked against a plain-arithmetic reference.
module tb_fp_cplx_scale_up;

  localparam int SHIFT = 5;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [31:0]      s_re = '0;
  logic [31:0]      s_img = '0;
  logic             s_last = 1'b0;
  logic             m_valid;
  logic             m_ready = 1'b1;
  logic [31:0]      m_re;
  logic [31:0]      m_img;
  logic             m_last;
  logic [CNT_W-1:0] ovf_cnt;
  logic             clr_cnt = 1'b0;

  fp_cplx_scale_up #(.SHIFT(SHIFT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_img(s_img), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_img(m_img), .m_last(m_last),
    .ovf_cnt(ovf_cnt), .clr_cnt(clr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] re;
    logic [31:0] img;
    logic        last;
    logic        ovf;
    logic        clr;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   mcnt  = 0;
  bit   drv_done;

  // Reference: scaling by 2^SHIFT on a normal number is adding SHIFT to the exponent field
  function automatic logic [31:0] ref_scale(input logic [31:0] w, output logic ovf);
    int e;
    e   = int'(w[30:23]);
    ovf = 1'b0;
    if (e == 0) return {w[31], 31'h0};
    if (e == 255) return w;
    if (e + SHIFT > 254) begin
      ovf = 1'b1;
`ifdef FP_SCALE_SAT_EN
      return {w[31], 31'h7F7FFFFF};
`else
      return {w[31], 31'h7F800000};
`endif
    end
    return w + (32'(SHIFT) << 23);
  endfunction

  function automatic logic [31:0] rnd_word();
    logic [7:0] e;
    case ($urandom_range(0, 5))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       e = 8'($urandom_range(245, 254));
      3:       e = 8'($urandom_range(1, 254));
      default: e = 8'($urandom_range(100, 160));
    endcase
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that took the sample.
  task automatic send(input logic [31:0] re, input logic [31:0] img, input logic last,
                      input logic clr);
    exp_t x;
    logic o1, o2;
    s_valid = 1'b1;
    s_re    = re;
    s_img   = img;
    s_last  = last;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (s_ready) break;
      if (n > 500) begin
        chk("send_timeout", 32'(s_ready), 32'd1);
        s_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    x.re   = ref_scale(re, o1);
    x.img  = ref_scale(img, o2);
    x.last = last;
    x.ovf  = o1 | o2;
    x.clr  = clr;
    sb.push_back(x);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  // Monitor: a transfer happens at the next rising edge when valid && ready here
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (rst_n && m_valid && m_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'(m_valid), 32'd0);
        end else begin
          x = sb.pop_front();
          if (x.clr) mcnt = 0;
          else if (x.ovf && mcnt < CMAX) mcnt++;
          chk("m_re", m_re, x.re);
          chk("m_img", m_img, x.img);
          chk("m_last", 32'(m_last), 32'(x.last));
          chk("ovf_cnt", 32'(ovf_cnt), 32'(mcnt));
        end
      end
    end
  end

  task automatic drain();
    for (int n = 0; n < 1000 && sb.size() != 0; n++) @(posedge clk);
    #1;
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] h_re, h_img;
    logic        h_last;

    // reset state
    #2;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_re", m_re, 32'd0);
    chk("rst_m_img", m_img, 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // basic scaling and latency
    send(32'h3F800000, 32'hBF000000, 1'b0, 1'b0);
    chk("lat_not_early", 32'(m_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_valid", 32'(m_valid), 32'd1);
    chk("basic_re", m_re, 32'h42000000);
    chk("basic_img", m_img, 32'hC1800000);
    drain();

    // overflow, then zero/denormal/special
    send(32'h7F000000, 32'h3F800000, 1'b0, 1'b0);
    drain();
    chk("ovf_one", 32'(ovf_cnt), 32'd1);
    send(32'h80000001, 32'h7FC00001, 1'b0, 1'b0);
    drain();
    chk("special_cnt", 32'(ovf_cnt), 32'd1);

    // backpressure: four back-to-back samples, downstream stalled for a while
    m_ready = 1'b0;
    fork
      begin
        send(32'h3F800000, 32'h40000000, 1'b0, 1'b0);
        send(32'h40400000, 32'h40800000, 1'b0, 1'b0);
        send(32'hC0A00000, 32'h00000000, 1'b0, 1'b0);
        send(32'h7F800000, 32'h3E800000, 1'b1, 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("bp_valid", 32'(m_valid), 32'd1);
        chk("bp_s_ready", 32'(s_ready), 32'd0);
        h_re = m_re; h_img = m_img; h_last = m_last;
        repeat (3) begin
          @(negedge clk);
          chk("bp_hold_re", m_re, h_re);
          chk("bp_hold_img", m_img, h_img);
          chk("bp_hold_last", 32'(m_last), 32'(h_last));
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    drain();

    // clear coinciding with an overflowing sample entering stage 2
    send(32'hFF000000, 32'h3F800000, 1'b0, 1'b1);
    clr_cnt = 1'b1;
    @(posedge clk);
    #1 clr_cnt = 1'b0;
    drain();
    chk("clr_prio", 32'(ovf_cnt), 32'd0);

    // saturation
    for (int i = 0; i < 5; i++) send(32'h7E800000 | 32'(i), 32'h7F7FFFFF, 1'b0, 1'b0);
    drain();
    chk("cnt_sat", 32'(ovf_cnt), 32'(CMAX));

    // reset with two samples in flight
    send(32'h7F000000, 32'h00000000, 1'b0, 1'b0);
    send(32'h3F800000, 32'h7F000000, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(m_valid), 32'd0);
    chk("midrst_cnt", 32'(ovf_cnt), 32'd0);
    sb.delete();
    mcnt = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(32'h41200000, 32'hC2C80000, 1'b1, 1'b0);
    chk("post_rst_not_early", 32'(m_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(m_valid), 32'd1);
    chk("post_rst_re", m_re, 32'h43A00000);
    chk("post_rst_img", m_img, 32'hC5480000);
    drain();

    // random traffic with random backpressure
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          send(rnd_word(), rnd_word(), 1'($urandom), 1'b0);
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk);
          #1 m_ready = ($urandom_range(0, 3) != 0);
        end
        m_ready = 1'b1;
      end
    join
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_cplx_scale_up.md
# fp_cplx_scale_up

Streaming, pipelined complex IEEE-754 single-precision scaler that multiplies both the real and imaginary parts by 2^SHIFT by adding SHIFT to each biased exponent. It is the inverse of the divide-by-32 exponent-subtract stage and sits at the output of the radix-5 FFT datapath, restoring the magnitude removed by the per-stage 1/32 scaling. It handles the exponent-range edge cases that a bare exponent adder ignores: zero or denormal inputs, Inf/NaN inputs, and overflow.

## Interface
Parameters:
- SHIFT, default 5: exponent increment. Legal range is 1..31.
- CNT_W, default 16: width of the overflow counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  block can accept an input sample.
- s_re  in  32  input real part, IEEE-754 single.
- s_img  in  32  input imaginary part, IEEE-754 single.
- s_last  in  1  last sample of the frame; passed through unchanged.
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream can accept.
- m_re  out  32  scaled real part.
- m_img  out  32  scaled imaginary part.
- m_last  out  1  delayed copy of s_last.
- ovf_cnt  out  CNT_W  count of samples in which either component overflowed.
- clr_cnt  in  1  synchronous clear of ovf_cnt.

## Operation
Each component is processed independently. Its fields are sign s = bit 31, exponent e = bits 30:23, mantissa m = bits 22:0.
- Sign is always passed through.
- e == 0 (zero or denormal): output is signed zero, {s, 8'h00, 23'h0]. Denormals are flushed.
- e == 255 (Inf/NaN): the word is passed through bit-exact.
- Otherwise form the 9-bit sum e9 = e + SHIFT:
  - e9 <= 254: output is {s, e9[7:0], m}.
  - e9 >= 255: overflow. Output depends on FP_SCALE_SAT_EN (see Configuration). The overflow flag is set for this component.
- A sample overflows if either component overflows. Each overflowing sample increments ovf_cnt by 1. The counter saturates at all-ones and does not wrap.
- clr_cnt takes priority over an increment in the same cycle: ovf_cnt becomes 0.
- Handshake is valid/ready:
  - A transfer occurs on any cycle where valid && ready.
  - m_valid, m_re, m_img and m_last stay stable while m_valid && !m_ready.
- Samples leave in arrival order. There is no loss and no duplication.

## Timing
- Two register stages:
  - Stage 1: field split, classification, exponent add, overflow flag.
  - Stage 2: output word assembly and ovf_cnt update.
- Latency is 2 cycles from the input transfer to m_valid when m_ready is held high. Throughput is 1 sample per cycle.
- Stall control uses a global enable, en = !m_valid || m_ready.
  - s_ready = en.
  - Both stages advance only when en is high.
  - Bubbles inside the pipe are not collapsed.
- ovf_cnt updates in the same cycle the overflowing sample enters stage 2. The increment happens exactly once per sample, even if that sample then stalls.
- Reset values: stage valids 0, m_valid 0, m_re 0, m_img 0, m_last 0, ovf_cnt 0. s_ready reads 1 during and after reset.
- Reset asserted mid-stream discards all in-flight samples immediately. No partial output is produced.

## Configuration
- FP_SCALE_SAT_EN defined: an overflowing component saturates to the largest finite magnitude, {s, 8'hFE, 23'h7FFFFF}.
- FP_SCALE_SAT_EN undefined: an overflowing component becomes signed infinity, {s, 8'hFF, 23'h0}.
- ovf_cnt counts overflows identically in both builds.

## Structure
- Package fp_scale_pkg holds:
  - constants: EXP_W = 8, MAN_W = 23, EXP_MAX = 8'hFF, EXP_MAX_FINITE = 8'hFE;
  - a classification enum: ZERO, NORMAL, SPECIAL;
  - a per-component stage-1 record: sign, class, 9-bit exponent sum, mantissa, overflow flag.
- Sub-module fp_exp_scale is the combinational single-component classify-and-add logic. It is instantiated twice, once for re and once for img. The top level owns the pipeline registers, the handshake and the counter.

## Test plan
- Basic scaling, m_ready held high: s_re = 0x3F800000 (1.0), s_img = 0xBF000000 (-0.5) -> m_re = 0x42000000 (32.0), m_img = 0xC1800000 (-16.0), arriving exactly 2 cycles after the input transfer; ovf_cnt = 0.
- Overflow: s_re = 0x7F000000, s_img = 0x3F800000 -> m_re = 0x7F800000 (without FP_SCALE_SAT_EN) or 0x7F7FFFFF (with it), m_img = 0x42000000, ovf_cnt = 1.
- Zero, denormal and special inputs: s_re = 0x80000001, s_img = 0x7FC00001 -> m_re = 0x80000000, m_img = 0x7FC00001, ovf_cnt unchanged.
- Backpressure: 4 back-to-back samples with s_last set on the 4th, m_ready held low for 5 cycles and then high -> s_ready drops, output data holds stable, all 4 samples emerge in order, m_last is set only on the 4th.
- Counter behaviour:
  - With CNT_W = 2, 5 overflowing samples -> ovf_cnt saturates at 3.
  - clr_cnt asserted in the same cycle as an overflowing sample -> ovf_cnt = 0.
- Reset mid-stream: rst_n pulsed low while 2 samples are in flight -> m_valid = 0 and ovf_cnt = 0 immediately; the next input appears 2 cycles after its transfer with the correct value.
